// File: rtl/xor_parity_acc.sv
// Frame-wise XOR accumulator with a parity flag.
// Accepts up to MAX_LEN words per frame and holds the result until the consumer takes it.
module xor_parity_acc #(
  parameter int WIDTH   = 8,
  parameter int MAX_LEN = 16
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic                               IN_VALID,
  output logic                               IN_READY,
  input  logic [WIDTH-1:0]                   IN_DATA,
  input  logic                               IN_LAST,
  input  logic                               MODE,
  output logic                               OUT_VALID,
  input  logic                               OUT_READY,
  output logic [WIDTH-1:0]                   OUT_WORD,
  output logic                               OUT_PAR,
  output logic [$clog2(MAX_LEN+1)-1:0]       OUT_COUNT,
  output logic                               OUT_ERR
);

  localparam int CW = $clog2(MAX_LEN + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    count_q, count_d;
  logic             mode_q, mode_d;
  logic             err_q, err_d;

  // Next-state and datapath update; everything holds unless a transfer or handshake occurs.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    mode_d  = mode_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (IN_VALID) begin
          acc_d   = IN_DATA;
          count_d = CW'(1);
          mode_d  = MODE;
          err_d   = 1'b0;
          state_d = IN_LAST ? ST_DONE : ST_ACCUM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (IN_VALID) begin
          acc_d   = acc_q ^ IN_DATA;
          count_d = count_q + CW'(1);
          // Reaching MAX_LEN without IN_LAST closes the frame as truncated.
          if (IN_LAST || (count_q == CW'(MAX_LEN - 1))) begin
            state_d = ST_DONE;
            err_d   = ~IN_LAST;
          end else begin
            state_d = ST_ACCUM;
          end
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_DONE: begin
        if (OUT_READY) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      count_q <= '0;
      mode_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
    end
  end

  assign IN_READY  = (state_q != ST_DONE);
  assign OUT_VALID = (state_q == ST_DONE);
  assign OUT_WORD  = acc_q;
  assign OUT_PAR   = (^acc_q) ^ mode_q;
  assign OUT_COUNT = count_q;
  assign OUT_ERR   = err_q;

endmodule

// File: tb/tb_xor_parity_acc.sv
// Directed bench for xor_parity_acc: default instance plus a MAX_LEN=4 instance for truncation.
module tb_xor_parity_acc;

  logic       clk;
  logic       rst;

  logic       in_valid_a, in_ready_a, in_last_a, mode_a;
  logic [7:0] in_data_a;
  logic       out_valid_a, out_ready_a, out_par_a, out_err_a;
  logic [7:0] out_word_a;
  logic [4:0] out_count_a;

  logic       in_valid_b, in_ready_b, in_last_b, mode_b;
  logic [7:0] in_data_b;
  logic       out_valid_b, out_ready_b, out_par_b, out_err_b;
  logic [7:0] out_word_b;
  logic [2:0] out_count_b;

  int passed = 0;
  int total  = 0;

  xor_parity_acc #(.WIDTH(8), .MAX_LEN(16)) dut_a (
    .CLK(clk), .RST(rst),
    .IN_VALID(in_valid_a), .IN_READY(in_ready_a), .IN_DATA(in_data_a),
    .IN_LAST(in_last_a), .MODE(mode_a),
    .OUT_VALID(out_valid_a), .OUT_READY(out_ready_a), .OUT_WORD(out_word_a),
    .OUT_PAR(out_par_a), .OUT_COUNT(out_count_a), .OUT_ERR(out_err_a)
  );

  xor_parity_acc #(.WIDTH(8), .MAX_LEN(4)) dut_b (
    .CLK(clk), .RST(rst),
    .IN_VALID(in_valid_b), .IN_READY(in_ready_b), .IN_DATA(in_data_b),
    .IN_LAST(in_last_b), .MODE(mode_b),
    .OUT_VALID(out_valid_b), .OUT_READY(out_ready_b), .OUT_WORD(out_word_b),
    .OUT_PAR(out_par_b), .OUT_COUNT(out_count_b), .OUT_ERR(out_err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send_a(input logic [7:0] d, input logic last, input logic m);
    in_valid_a = 1'b1;
    in_data_a  = d;
    in_last_a  = last;
    mode_a     = m;
    tick();
    in_valid_a = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] d, input logic last);
    in_valid_b = 1'b1;
    in_data_b  = d;
    in_last_b  = last;
    mode_b     = 1'b0;
    tick();
    in_valid_b = 1'b0;
  endtask

  task automatic chk_a(input string tag, input logic [7:0] w, input logic p,
                       input logic [4:0] c, input logic e);
    chk({tag, "_valid"}, {31'd0, out_valid_a}, 32'd1);
    chk({tag, "_word"},  {24'd0, out_word_a},  {24'd0, w});
    chk({tag, "_par"},   {31'd0, out_par_a},   {31'd0, p});
    chk({tag, "_count"}, {27'd0, out_count_a}, {27'd0, c});
    chk({tag, "_err"},   {31'd0, out_err_a},   {31'd0, e});
  endtask

  initial begin
    rst = 1'b1;
    in_valid_a = 1'b0; in_data_a = 8'h00; in_last_a = 1'b0; mode_a = 1'b0; out_ready_a = 1'b0;
    in_valid_b = 1'b0; in_data_b = 8'h00; in_last_b = 1'b0; mode_b = 1'b0; out_ready_b = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset values
    chk("rst_valid", {31'd0, out_valid_a}, 32'd0);
    chk("rst_ready", {31'd0, in_ready_a},  32'd1);
    chk("rst_word",  {24'd0, out_word_a},  32'd0);
    chk("rst_par",   {31'd0, out_par_a},   32'd0);
    chk("rst_count", {27'd0, out_count_a}, 32'd0);
    chk("rst_err",   {31'd0, out_err_a},   32'd0);

    // Basic even-parity frame: A5 ^ 0F ^ 3C = 96, four ones -> par 0
    send_a(8'hA5, 1'b0, 1'b0);
    send_a(8'h0F, 1'b0, 1'b0);
    chk("f1_midvalid", {31'd0, out_valid_a}, 32'd0);
    send_a(8'h3C, 1'b1, 1'b0);
    chk_a("f1", 8'h96, 1'b0, 5'd3, 1'b0);
    out_ready_a = 1'b1;
    tick();
    out_ready_a = 1'b0;
    chk("f1_release", {31'd0, out_valid_a}, 32'd0);
    chk("f1_rdy",     {31'd0, in_ready_a},  32'd1);

    // Odd mode latched on first word only; idle gap with junk data must be ignored
    send_a(8'hA5, 1'b0, 1'b1);
    in_data_a = 8'hFF; in_last_a = 1'b1; mode_a = 1'b0;
    tick();
    chk("f2_gap_valid", {31'd0, out_valid_a}, 32'd0);
    send_a(8'h0F, 1'b0, 1'b0);
    send_a(8'h3C, 1'b1, 1'b0);
    chk_a("f2", 8'h96, 1'b1, 5'd3, 1'b0);

    // Back-pressure: IN_VALID held high in DONE must not consume words
    in_valid_a = 1'b1; in_data_a = 8'h55; in_last_a = 1'b1; mode_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_rdy", {31'd0, in_ready_a}, 32'd0);
      chk_a("hold", 8'h96, 1'b1, 5'd3, 1'b0);
    end
    in_valid_a = 1'b0;
    out_ready_a = 1'b1;
    tick();
    out_ready_a = 1'b0;
    chk("hold_release", {31'd0, out_valid_a}, 32'd0);

    // Reset mid-frame discards it, even with a concurrent transfer
    send_a(8'h11, 1'b0, 1'b1);
    send_a(8'h22, 1'b0, 1'b0);
    rst = 1'b1;
    in_valid_a = 1'b1; in_data_a = 8'h44; in_last_a = 1'b1;
    tick();
    rst = 1'b0;
    in_valid_a = 1'b0;
    chk("mrst_valid", {31'd0, out_valid_a}, 32'd0);
    chk("mrst_ready", {31'd0, in_ready_a},  32'd1);
    chk("mrst_word",  {24'd0, out_word_a},  32'd0);
    chk("mrst_par",   {31'd0, out_par_a},   32'd0);
    chk("mrst_count", {27'd0, out_count_a}, 32'd0);
    chk("mrst_err",   {31'd0, out_err_a},   32'd0);
    send_a(8'hFF, 1'b1, 1'b0);
    chk_a("ff", 8'hFF, 1'b0, 5'd1, 1'b0);
    out_ready_a = 1'b1;
    tick();
    out_ready_a = 1'b0;

    // Single-word frame: 01 has one set bit -> par 1
    send_a(8'h01, 1'b1, 1'b0);
    chk_a("one", 8'h01, 1'b1, 5'd1, 1'b0);
    out_ready_a = 1'b1;
    tick();
    out_ready_a = 1'b0;

    // Truncation at MAX_LEN=4: 01^02^04^08 = 0F, err set; fifth word waits
    send_b(8'h01, 1'b0);
    send_b(8'h02, 1'b0);
    send_b(8'h04, 1'b0);
    send_b(8'h08, 1'b0);
    chk("tr_valid", {31'd0, out_valid_b}, 32'd1);
    chk("tr_word",  {24'd0, out_word_b},  32'h0F);
    chk("tr_count", {29'd0, out_count_b}, 32'd4);
    chk("tr_err",   {31'd0, out_err_b},   32'd1);
    chk("tr_par",   {31'd0, out_par_b},   32'd0);
    chk("tr_rdy",   {31'd0, in_ready_b},  32'd0);
    in_valid_b = 1'b1; in_data_b = 8'h10; in_last_b = 1'b1;
    out_ready_b = 1'b1;
    tick();
    out_ready_b = 1'b0;
    chk("tr_release", {31'd0, out_valid_b}, 32'd0);
    tick();
    in_valid_b = 1'b0;
    chk("tr2_valid", {31'd0, out_valid_b}, 32'd1);
    chk("tr2_word",  {24'd0, out_word_b},  32'h10);
    chk("tr2_count", {29'd0, out_count_b}, 32'd1);
    chk("tr2_err",   {31'd0, out_err_b},   32'd0);
    chk("tr2_par",   {31'd0, out_par_b},   32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
